// File: rtl/xlib_avalon_ram_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : xlib_avalon_ram_mp
// Purpose  : Multi-port Avalon-style behavioural RAM. NP master ports share
//            one byte-addressed memory through a round-robin arbiter, with
//            byte enables, address-once bursts, fixed read latency and
//            pseudo-random backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module xlib_avalon_ram_mp #(
  parameter int NP        = 4,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BL        = 4,
  parameter int BI        = 1,
  parameter int SZ        = 2**20,
  parameter int RD_LAT    = 2,
  parameter int ARDY_RATE = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [NP-1:0]        rrdy,
  input  logic [NP-1:0]        rval,
  input  logic [NP*BL-1:0]     rlen,
  input  logic [NP*AW-1:0]     raddr,
  output logic [DW-1:0]        rdata,
  output logic [NP-1:0]        rdval,
  output logic [NP-1:0]        wrdy,
  input  logic [NP-1:0]        wval,
  input  logic [NP*BL-1:0]     wlen,
  input  logic [NP*AW-1:0]     waddr,
  input  logic [NP*DW-1:0]     wdata,
  input  logic [NP*DW/8-1:0]   wbe
);

  localparam int BS    = DW / 8;
  localparam int AL    = (BS > 1) ? $clog2(BS) : 0;
  localparam int MW    = $clog2(SZ);
  localparam int IW    = MW - AL;
  localparam int DEPTH = SZ / BS;
  localparam int PW    = (NP > 1) ? $clog2(NP) : 1;
  localparam int CW    = BL + 1;
  localparam logic [CW-1:0] C_BI = CW'(BI);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [IW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wbuf_q, wbuf_d;
  logic [BS-1:0]   wbe_q, wbe_d;
  logic            wfull_q, wfull_d;
  logic [31:0]     lfsr_q, lfsr_d;
  logic            mrdy;

  logic            free, wacc, mem_we, len_bad;
  logic            push_v;
  logic [PW-1:0]   push_id;
  logic [IW-1:0]   push_addr;
  logic [DW-1:0]   push_data;
  logic            arb_found;
  logic [PW-1:0]   arb_idx, arb_g;
  logic [CW-1:0]   beats;
  int              gi;

  logic [DW-1:0]   mem_q [DEPTH];

  logic            pv_q  [RD_LAT];
  logic [PW-1:0]   pid_q [RD_LAT];
  logic [DW-1:0]   pd_q  [RD_LAT];

  // Address bits outside the word index are ignored by design.
  logic            w_unused_ok;
  assign w_unused_ok = ^{raddr, waddr};

  // Backpressure source: xorshift32 scaled to a percentage.
  always_comb begin
    lfsr_d = lfsr_q ^ (lfsr_q << 13);
    lfsr_d = lfsr_d ^ (lfsr_d >> 17);
    lfsr_d = lfsr_d ^ (lfsr_d << 5);
  end

  assign mrdy = (ARDY_RATE >= 100) ? 1'b1 : ((lfsr_q % 32'd100) < 32'(ARDY_RATE));

  // Engine next-state, arbitration and port handshakes.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    wbuf_d    = wbuf_q;
    wbe_d     = wbe_q;
    wfull_d   = wfull_q;
    rrdy      = '0;
    wrdy      = '0;
    push_v    = 1'b0;
    push_id   = gnt_q;
    push_addr = addr_q;
    mem_we    = 1'b0;
    free      = 1'b0;
    wacc      = 1'b0;
    len_bad   = 1'b0;
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_g     = '0;
    beats     = '0;
    gi        = 0;

    case (state_q)
      S_IDLE: free = 1'b1;
      S_WR: begin
        // One-beat buffer: a new beat is taken only when the buffer empties.
        mem_we = wfull_q & mrdy;
        if (rem_q != '0) begin
          wrdy[gnt_q] = ~wfull_q | mem_we;
          wacc        = (~wfull_q | mem_we) & wval[gnt_q];
        end
        if (wacc) begin
          wbuf_d = wdata[int'(gnt_q)*DW +: DW];
          wbe_d  = wbe[int'(gnt_q)*BS +: BS];
          rem_d  = rem_q - CW'(1);
        end
        if (mem_we) addr_d = addr_q + IW'(1);
        wfull_d = wacc | (wfull_q & ~mem_we);
        if (mem_we && (rem_q == '0)) begin
          state_d = S_IDLE;
          free    = 1'b1;
        end
      end
      S_RD: begin
        if (mrdy) begin
          push_v = 1'b1;
          addr_d = addr_q + IW'(1);
          rem_d  = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = S_IDLE;
            free    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Grant may happen in the same cycle the previous burst finishes.
    if (free && rst_n) begin
      for (int i = 0; i < NP; i++) begin
        arb_idx = PW'((int'(rr_q) + i) % NP);
        if (!arb_found && (rval[arb_idx] | wval[arb_idx])) begin
          arb_found = 1'b1;
          arb_g     = arb_idx;
        end
      end
      if (arb_found) begin
        gi           = int'(arb_g);
        wrdy[arb_g]  = 1'b1;
        rrdy[arb_g]  = ~wval[arb_g];
        gnt_d        = arb_g;
        rr_d         = PW'((gi + 1) % NP);
        if (wval[arb_g]) begin
          beats   = {1'b0, wlen[gi*BL +: BL]} - C_BI + CW'(1);
          len_bad = (BI == 1) && (wlen[gi*BL +: BL] == '0);
          wbuf_d  = wdata[gi*DW +: DW];
          wbe_d   = wbe[gi*BS +: BS];
          wfull_d = 1'b1;
          addr_d  = waddr[gi*AW + AL +: IW];
          rem_d   = beats - CW'(1);
          state_d = S_WR;
        end else begin
          beats   = {1'b0, rlen[gi*BL +: BL]} - C_BI + CW'(1);
          len_bad = (BI == 1) && (rlen[gi*BL +: BL] == '0);
          if (state_q == S_RD) begin
            // Read pipeline is busy with the previous last beat this cycle.
            addr_d  = raddr[gi*AW + AL +: IW];
            rem_d   = beats;
            state_d = S_RD;
          end else begin
            push_v    = 1'b1;
            push_id   = arb_g;
            push_addr = raddr[gi*AW + AL +: IW];
            addr_d    = raddr[gi*AW + AL +: IW] + IW'(1);
            rem_d     = beats - CW'(1);
            state_d   = (beats == CW'(1)) ? S_IDLE : S_RD;
          end
        end
      end
    end
  end

  // Engine state registers; burst context is abandoned on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      wbe_q   <= '0;
      wfull_q <= 1'b0;
      lfsr_q  <= 32'h2545_F491;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      wbe_q   <= wbe_d;
      wfull_q <= wfull_d;
      if (state_q != S_IDLE) lfsr_q <= lfsr_d;
    end
  end

  // Memory array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BS; b++) begin
        if (wbe_q[b]) mem_q[addr_q][b*8 +: 8] <= wbuf_q[b*8 +: 8];
      end
    end
  end

  assign push_data = mem_q[push_addr];

  // Read latency pipeline; data stages hold when no beat passes through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i]  <= 1'b0;
        pid_q[i] <= '0;
        pd_q[i]  <= '0;
      end
    end else begin
      pv_q[0] <= push_v;
      if (push_v) begin
        pid_q[0] <= push_id;
        pd_q[0]  <= push_data;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) begin
          pid_q[i] <= pid_q[i-1];
          pd_q[i]  <= pd_q[i-1];
        end
      end
    end
  end

  // One-hot response strobe for the port owning the emerging beat.
  always_comb begin
    rdval = '0;
    if (pv_q[RD_LAT-1]) rdval[pid_q[RD_LAT-1]] = 1'b1;
  end

  assign rdata = pd_q[RD_LAT-1];

  a_no_x_req: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({rval, wval}));
  a_len_legal: assert property (@(posedge clk) disable iff (!rst_n) !len_bad);

endmodule
`default_nettype wire

// File: doc/xlib_avalon_ram_mp.md
Name: xlib_avalon_ram_mp

Overview:
- Multi-port Avalon-style behavioural RAM model for DMA/interconnect test benches.
- NP independent master ports share one byte-addressed memory through a round-robin arbiter.
- Adds per-port byte enables, address-once write bursts, configurable read latency and random backpressure.
- Used as the slave under multi-channel DMA read/write benches.

Parameters:
- NP, 4, number of master ports (1..16)
- AW, 32, address width (byte address)
- DW, 32, data width; multiple of 8
- BL, 4, burst length field width
- BI, 1, burst encoding: 0 means len L = L+1 beats; 1 means len L = L beats (L=0 illegal)
- SZ, 2**20, memory size in bytes; power of 2
- RD_LAT, 2, cycles from accepted read beat to rdval (>=1)
- ARDY_RATE, 100, per-beat percent probability the engine is ready (1..100)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rrdy  out  NP  per-port read command ready
- rval  in  NP  per-port read command valid
- rlen  in  NP*BL  per-port read burst length, port p at [p*BL+:BL]
- raddr  in  NP*AW  per-port read start address
- rdata  out  DW  shared read data bus
- rdval  out  NP  one-hot read data valid; bit p marks data for port p
- wrdy  out  NP  per-port write beat ready
- wval  in  NP  per-port write beat valid
- wlen  in  NP*BL  write burst length; sampled on first beat only
- waddr  in  NP*AW  write start address; sampled on first beat only
- wdata  in  NP*DW  write data per beat
- wbe  in  NP*DW/8  byte enables per beat

Behaviour:
- Derived values: BS=DW/8, AL=log2(BS). Memory word index is addr[log2(SZ)-1:AL], so addresses wrap modulo SZ.
- Start addresses are aligned down to BS. Each later beat adds BS.
- Beats per burst: len-BI+1.
- Beat accept: mrdy is re-randomised every cycle the engine is busy; mrdy=1 with probability ARDY_RATE/100. With ARDY_RATE=100, mrdy is always 1.
- FSM states: IDLE, RD, WR.
- IDLE:
  - Port requests are req[p]=rval[p]|wval[p].
  - The arbiter grants the first requesting port at or after rr_ptr, scanning upward with wrap. Grant is combinational.
  - Within the granted port, write has priority: wrdy[g]=1, rrdy[g]=~wval[g]. All other ports see rrdy=wrdy=0.
  - On accept, latch port id, length, address and first beat data/byte enables, then go to RD or WR. rr_ptr becomes g+1 mod NP.
- WR:
  - The latched beat commits to memory when mrdy=1; only bytes with wbe=1 are written.
  - For subsequent beats, wrdy[g]=1 only when the prior beat commits this cycle (one-beat buffer). Other ports are locked out.
  - The last beat commits -> IDLE. If another request is present the same cycle, it may be granted in that cycle (back-to-back, zero bubble).
- RD:
  - One beat is read per cycle with mrdy=1, down-counting length.
  - The beat is pushed into an RD_LAT-deep pipeline carrying data and port id.
  - rdval[id] is asserted exactly RD_LAT cycles after the beat is accepted.
  - The last beat -> IDLE, with the same back-to-back rule as WR.
- rdata: holds its last value when rdval=0. Memory contents are unspecified before first write (X allowed).
- Ordering:
  - A write beat committed in cycle N is visible to any read beat accepted in cycle N+1 or later.
  - Responses never reorder: rdval order equals grant order.
- No reads and writes are in flight simultaneously; the single engine serialises all ports.
- Reset (async, any time):
  - FSM goes to IDLE, rr_ptr=0, read pipeline flushed.
  - rdval=0, rdata=0, rrdy=wrdy=0 while rst_n=0.
  - Memory contents are preserved; any in-progress burst is abandoned.
- Illegal input (BI=1 with len=0, X on rval/wval) fires a simulation assertion and is otherwise undefined.

Test Plan:
- Single-beat write/read: NP=4, ARDY_RATE=100, port 2 writes 0xA5A5_1234 at 0x100 with wbe=0xF, then port 0 reads len=1 at 0x100 -> rdval=4'b0001 RD_LAT=2 cycles after rrdy&rval, rdata=0xA5A5_1234.
- Round-robin: all 4 ports hold rval, len=2 -> grants in order 0,1,2,3,0…; each port gets 2 consecutive rdval beats; no port is starved.
- Write burst with byte enables: port 1 writes wlen=4 at 0x203 with beats 0x11111111..0x44444444, beat 2 wbe=0x3 -> bursts start at 0x200; readback of beat 2 keeps the upper 16 bits of prior content; the other ports see wrdy=0 throughout.
- BI=0 mode: rlen=3 -> exactly 4 rdval beats at addresses +0,+4,+8,+C.
- Backpressure: ARDY_RATE=30, random concurrent traffic on all ports, 10k beats -> scoreboard matches every beat; rdval is always one-hot; per-port response order is preserved.
- Wrap and reset: read len=4 at SZ-8 -> beats 3-4 return memory[0],memory[4]. Assert rst_n=0 mid-burst -> rdval=0 immediately; after release a new read returns correct data and grant starts at port 0.
